// File: rtl/ifu_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
// Combinational read: instr_in reflects pc in the same cycle.
interface ifu_if;
    logic [31:0] pc;
    logic [31:0] instr_in;

    modport master (output pc, input instr_in);
    modport slave  (input pc, output instr_in);
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, next-PC select, IF/ID pipeline register with fetch-fault flag.
// Latency: fetch combinational through imem; IF/ID updates one cycle after pc presents the address.
// Backpressure: stall holds pc and all IF/ID state; redirect inputs are ignored while stalled.
module ifu #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    ifu_if.master       imem,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_fault
);

    localparam logic [31:0] PC_LAST = PC_RESET + 32'(IM_WORDS * 4) - 32'd4;

    logic [31:0] pc_q;
    logic [31:0] npc;
    logic [31:0] br_off;
    logic        fault;

    assign imem.pc = pc_q;
    assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};
    assign fault   = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET) || (pc_q > PC_LAST);

    // Branch and jump targets are relative to the instruction in ID, not the delay slot being fetched.
    always_comb begin
        npc = pc_q + 32'd4;
        case (npc_sel)
            2'd1:    if (br_taken) npc = id_pc + 32'd4 + br_off;
            2'd2:    npc = {id_pc[31:28], imm26, 2'b00};
            2'd3:    npc = jr_target;
            default: npc = pc_q + 32'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= PC_RESET;
            id_instr <= 32'd0;
            id_pc    <= PC_RESET;
            id_pc8   <= PC_RESET + 32'd8;
            id_fault <= 1'b0;
        end else if (!stall) begin
            pc_q     <= npc;
            id_instr <= fault ? 32'd0 : imem.instr_in;
            id_pc    <= pc_q;
            id_pc8   <= pc_q + 32'd8;
            id_fault <= fault;
        end
    end

endmodule
